// File: rtl/exec_ctrl.sv
// exec_ctrl: instruction sequencer for a simple multi-cycle CPU.
//
// Each instruction runs HALT -> FETCH -> READ -> EXEC -> WRITE, one cycle
// per phase. It free-runs while `run` is high. A rising edge on `step` while
// halted issues one instruction. A breakpoint stops the sequencer before the
// instruction at `bp_addr` is fetched.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high
//   run          level: 1 = free-run, 0 = halt after the current instruction
//   step         raw switch level; each 0->1 edge requests one instruction
//   bp_en        breakpoint enable
//   bp_addr      breakpoint program address
//   pc_addr      address from the pc block (shows next-pc while pc_en is high)
//   fetch_en     program-memory fetch strobe (FETCH only)
//   reg_rd_en    register-file read strobe (READ only)
//   reg_wr_en    register-file write-back strobe (WRITE only)
//   pc_en        pc advance/branch strobe (WRITE only)
//   halted       high exactly while the FSM is in HALT
//   instr_count  retired-instruction count, wraps
//   state_dbg    current FSM state encoding, for observation only
//
// Strobe semantics: the strobes are single-cycle qualifiers with no
// back-pressure. The consumers must act in the cycle a strobe is high.
// Each strobe is a flop loaded from the decoded next state, so it is
// glitch-free and lines up exactly with the state it belongs to.
module exec_ctrl #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic                 bp_en,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic [PC_WIDTH-1:0]  pc_addr,
    output logic                 fetch_en,
    output logic                 reg_rd_en,
    output logic                 reg_wr_en,
    output logic                 pc_en,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_FETCH = 3'd1,
        S_READ  = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t state, state_next;
    logic   step_q;
    logic   step_req;
    logic   single_shot, single_shot_next;
    // bp_hold is set when a breakpoint stopped the machine. While it is set,
    // `run` alone cannot restart the machine, so the halt holds even with run
    // high. A step edge resumes execution. Dropping `run` clears the hold, so
    // a later run assertion restarts normally.
    logic   bp_hold, bp_hold_next;
    logic   bp_hit;

    assign step_req  = step & ~step_q;
    // pc_addr carries the next-pc look-ahead during WRITE. Checking it here
    // decides the FETCH/HALT choice before the instruction is fetched.
    assign bp_hit    = bp_en && (pc_addr == bp_addr);
    assign state_dbg = state;

    always_comb begin
        state_next       = state;
        single_shot_next = single_shot;
        bp_hold_next     = bp_hold;
        case (state)
            S_HALT: begin
                if (bp_hold) begin
                    if (step_req) begin
                        state_next       = S_FETCH;
                        bp_hold_next     = 1'b0;
                        single_shot_next = ~run;
                    end else if (!run) begin
                        bp_hold_next = 1'b0;
                    end
                end else if (run || step_req) begin
                    // run has priority: a simultaneous step does not set
                    // single-shot mode.
                    state_next       = S_FETCH;
                    single_shot_next = step_req && !run;
                end
            end
            S_FETCH: state_next = S_READ;
            S_READ:  state_next = S_EXEC;
            S_EXEC:  state_next = S_WRITE;
            S_WRITE: begin
                single_shot_next = 1'b0;
                if (run && !single_shot && !bp_hit) begin
                    state_next = S_FETCH;
                end else begin
                    state_next   = S_HALT;
                    bp_hold_next = bp_hit;
                end
            end
            default: state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_HALT;
            step_q      <= 1'b0;
            single_shot <= 1'b0;
            bp_hold     <= 1'b0;
            instr_count <= '0;
            fetch_en    <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_wr_en   <= 1'b0;
            pc_en       <= 1'b0;
            halted      <= 1'b1;
        end else begin
            state       <= state_next;
            step_q      <= step;
            single_shot <= single_shot_next;
            bp_hold     <= bp_hold_next;
            if (state == S_WRITE) begin
                instr_count <= instr_count + CNT_WIDTH'(1);
            end
            fetch_en  <= (state_next == S_FETCH);
            reg_rd_en <= (state_next == S_READ);
            reg_wr_en <= (state_next == S_WRITE);
            pc_en     <= (state_next == S_WRITE);
            halted    <= (state_next == S_HALT);
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl. A small pc-block model advances pc_reg on pc_en and
// shows the next-pc look-ahead on pc_addr while pc_en is high. Tests push
// the pc of every instruction they expect to retire. A monitor pops and
// compares on each reg_wr_en pulse.
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        bp_en = 1'b0;
    logic [7:0]  bp_addr = 8'd0;
    logic [7:0]  pc_addr;
    logic        fetch_en, reg_rd_en, reg_wr_en, pc_en, halted;
    logic [15:0] instr_count;
    logic [2:0]  state_dbg;

    logic        w4_fetch_en, w4_reg_rd_en, w4_reg_wr_en, w4_pc_en, w4_halted;
    logic [3:0]  w4_instr_count;
    logic [2:0]  w4_state_dbg;

    logic [7:0]  pc_reg;
    logic [7:0]  pc_init = 8'd0;
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    exec_ctrl #(.PC_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc_addr(pc_addr), .fetch_en(fetch_en),
        .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en), .pc_en(pc_en),
        .halted(halted), .instr_count(instr_count), .state_dbg(state_dbg)
    );

    exec_ctrl #(.PC_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc_addr(pc_addr), .fetch_en(w4_fetch_en),
        .reg_rd_en(w4_reg_rd_en), .reg_wr_en(w4_reg_wr_en), .pc_en(w4_pc_en),
        .halted(w4_halted), .instr_count(w4_instr_count), .state_dbg(w4_state_dbg)
    );

    // pc block model
    always_ff @(posedge clk) begin
        if (reset)      pc_reg <= pc_init;
        else if (pc_en) pc_reg <= pc_reg + 8'd1;
    end
    assign pc_addr = pc_en ? pc_reg + 8'd1 : pc_reg;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Retirement scoreboard
    always @(negedge clk) begin
        if (!reset && reg_wr_en) begin
            check_val("pc_en_with_wr", 32'(pc_en), 32'd1);
            if (exp_q.size() == 0) check_val("retire_unexpected", 32'(pc_reg), 32'hFFFF_FFFF);
            else                   check_val("retire_pc", 32'(pc_reg), exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_halt(input int max_cycles);
        int n;
        n = 0;
        while (!halted && n < max_cycles) begin
            tick();
            n++;
        end
        if (!halted) check_val("halt_timeout", 32'(halted), 32'd1);
    endtask

    function automatic logic [3:0] strobes();
        return {fetch_en, reg_rd_en, reg_wr_en, pc_en};
    endfunction

    initial begin
        logic [3:0] pat [4];
        int fetches, busy;
        logic saw_wrap;
        logic [3:0] prev4;
        pat[0] = 4'b1000; pat[1] = 4'b0100; pat[2] = 4'b0000; pat[3] = 4'b0011;

        // Free run, three instructions then stop
        pc_init = 8'd0;
        do_reset();
        check_val("rst_halted", 32'(halted), 32'd1);
        check_val("rst_strobes", 32'(strobes()), 32'd0);
        check_val("rst_count", 32'(instr_count), 32'd0);
        run = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("run_strobes", 32'(strobes()), 32'(pat[i % 4]));
            check_val("run_halted", 32'(halted), 32'd0);
        end
        tick();
        check_val("run_count3", 32'(instr_count), 32'd3);
        check_val("run_halted_after", 32'(halted), 32'd0);
        run = 1'b0;
        exp_q.push_back(3);
        wait_halt(8);
        check_val("run_count4", 32'(instr_count), 32'd4);
        check_val("run_q_empty", exp_q.size(), 32'd0);

        // Single step with step held high
        do_reset();
        repeat (3) tick();
        check_val("step_idle_halted", 32'(halted), 32'd1);
        step = 1'b1;
        exp_q.push_back(0);
        fetches = 0; busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fetch_en) fetches++;
            if (!halted) busy++;
        end
        check_val("step_fetches", fetches, 32'd1);
        check_val("step_busy", busy, 32'd4);
        check_val("step_count", 32'(instr_count), 32'd1);
        check_val("step_halted", 32'(halted), 32'd1);
        check_val("step_q_empty", exp_q.size(), 32'd0);
        step = 1'b0;

        // Breakpoint at 5, pc starting at 3
        pc_init = 8'd3;
        do_reset();
        bp_en = 1'b1; bp_addr = 8'd5; run = 1'b1;
        exp_q.push_back(3); exp_q.push_back(4);
        tick();
        wait_halt(12);
        check_val("bp_count", 32'(instr_count), 32'd2);
        check_val("bp_pc", 32'(pc_reg), 32'd5);
        fetches = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fetch_en) fetches++;
            check_val("bp_hold_halted", 32'(halted), 32'd1);
        end
        check_val("bp_no_fetch", fetches, 32'd0);
        step = 1'b1;
        exp_q.push_back(5);
        tick();
        check_val("bp_resume_fetch", 32'(fetch_en), 32'd1);
        check_val("bp_resume_pc", 32'(pc_addr), 32'd5);
        run = 1'b0;
        wait_halt(8);
        check_val("bp_resume_count", 32'(instr_count), 32'd3);
        check_val("bp_q_empty", exp_q.size(), 32'd0);
        step = 1'b0; bp_en = 1'b0; pc_init = 8'd0;

        // Reset during EXEC
        do_reset();
        run = 1'b1;
        repeat (3) tick();
        check_val("abort_in_exec", 32'(state_dbg), 32'd3);
        reset = 1'b1;
        tick();
        check_val("abort_halted", 32'(halted), 32'd1);
        check_val("abort_wr", 32'(reg_wr_en), 32'd0);
        check_val("abort_count", 32'(instr_count), 32'd0);
        reset = 1'b0; run = 1'b0;
        repeat (2) tick();
        check_val("abort_count_later", 32'(instr_count), 32'd0);
        check_val("abort_halted_later", 32'(halted), 32'd1);

        // run dropped during READ
        do_reset();
        run = 1'b1;
        exp_q.push_back(0);
        tick();
        tick();
        check_val("drop_in_read", 32'(reg_rd_en), 32'd1);
        run = 1'b0;
        wait_halt(8);
        check_val("drop_count", 32'(instr_count), 32'd1);
        check_val("drop_q_empty", exp_q.size(), 32'd0);

        // Counter wrap on the 4-bit instance, with step noise while running
        do_reset();
        run = 1'b1;
        for (int i = 0; i <= 17; i++) exp_q.push_back(i);
        saw_wrap = 1'b0;
        prev4 = w4_instr_count;
        for (int i = 0; i < 69; i++) begin
            step = (i % 7 == 3);
            tick();
            if (prev4 == 4'd15 && w4_instr_count == 4'd0) saw_wrap = 1'b1;
            prev4 = w4_instr_count;
        end
        step = 1'b0;
        check_val("wrap_seen", 32'(saw_wrap), 32'd1);
        check_val("wrap_count4", 32'(w4_instr_count), 32'd1);
        check_val("wrap_count16", 32'(instr_count), 32'd17);
        run = 1'b0;
        wait_halt(8);
        check_val("wrap_q_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of program-counter address compared for breakpoints.
REQ-002 Parameter CNT_WIDTH, default 16, width of retired-instruction counter.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; 1 = free-run instructions, 0 = halt after current instruction.
REQ-006 step  input  1  raw level from switch; internally edge-detected, each 0->1 edge requests one instruction.
REQ-007 bp_en  input  1  breakpoint enable.
REQ-008 bp_addr  input  PC_WIDTH  breakpoint program address.
REQ-009 pc_addr  input  PC_WIDTH  current program-counter value from pc block.
REQ-010 fetch_en  output  1  program-memory fetch phase strobe.
REQ-011 reg_rd_en  output  1  register-file read phase strobe.
REQ-012 reg_wr_en  output  1  register-file write-back strobe.
REQ-013 pc_en  output  1  pc advance/branch strobe.
REQ-014 halted  output  1  1 while FSM in HALT.
REQ-015 instr_count  output  CNT_WIDTH  retired-instruction count.

Function
REQ-016 FSM states HALT, FETCH, READ, EXEC, WRITE; one instruction = FETCH->READ->EXEC->WRITE, exactly 4 cycles.
REQ-017 Strobes registered, one-hot by state: fetch_en=1 only in FETCH, reg_rd_en only in READ, reg_wr_en and pc_en only in WRITE; all 0 in HALT and EXEC.
REQ-018 halted=1 exactly when state is HALT.
REQ-019 step edge detect: step_req pulse when step=1 and registered step_q=0; step_q updates every cycle.
REQ-020 HALT->FETCH when run=1 or step_req=1; otherwise remain HALT.
REQ-021 A step_req while not in HALT is ignored (not queued).
REQ-022 Step mode latch single_shot set on HALT->FETCH caused by step_req with run=0; cleared on WRITE exit.
REQ-023 WRITE->FETCH when run=1, single_shot=0, and no breakpoint hit; else WRITE->HALT.
REQ-024 Breakpoint hit: bp_en=1 and pc_addr==bp_addr evaluated in WRITE on the next-pc value presented by pc block in the cycle after pc_en, i.e. checked at FETCH entry: if hit on entering FETCH from WRITE, FSM goes to HALT instead, no fetch_en asserted.
REQ-025 Resume from breakpoint: HALT->FETCH does not check breakpoint, so instruction at bp_addr executes once on resume.
REQ-026 run deasserted mid-instruction: current instruction completes through WRITE, then HALT.
REQ-027 instr_count increments by 1 on every WRITE cycle; wraps from all-ones to 0.
REQ-028 run=1 and step_req=1 simultaneously in HALT: treated as run (single_shot not set).

Reset
REQ-029 reset=1 at any clock edge forces HALT, single_shot=0, step_q=0, instr_count=0 next cycle, overriding all other inputs.
REQ-030 During and after reset, until leaving HALT: fetch_en=reg_rd_en=reg_wr_en=pc_en=0, halted=1.
REQ-031 Reset mid-instruction aborts it: no reg_wr_en/pc_en issued for the aborted instruction, instr_count not incremented.

Verification
REQ-032 Reset then run=1, bp_en=0 for 12 cycles -> strobe pattern FETCH,READ,EXEC,WRITE repeated 3x, instr_count=3, halted=0.
REQ-033 run=0, step toggled 0->1 and held 1 for 20 cycles -> exactly one 4-cycle instruction, instr_count=1, halted=1 thereafter.
REQ-034 run=1, bp_en=1, bp_addr=5, pc sequences 3,4,5 -> halt after instruction at 4 retires, no fetch_en at pc=5; run held 1 but FSM stays HALT until step edge, then instruction at 5 executes.
REQ-035 run=1, reset pulsed during EXEC -> next cycle halted=1, no reg_wr_en pulse, instr_count=0.
REQ-036 CNT_WIDTH=4, run=1 for 17 instructions -> instr_count wraps 15->0, reads 1 at end.
REQ-037 run dropped during READ -> instruction completes (reg_wr_en pulse seen), then halted=1, count +1.
